uart_num_parser: RTL and testbench



---
 rtl/uart_num_parser.sv | 176 +++++++++++++++++
 tb/tb_uart_num_parser.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_num_parser.sv
// uart_num_parser
// Turns the ASCII byte stream coming out of uart_rx into unsigned integer
// tokens for matrix_io_ctrl. Decimal digits build a token. Space or comma
// ends a token. CR or LF ends a token and the line. Any other byte rejects
// the current token.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   rx_data    received byte, qualified by rx_done
//   rx_done    one-cycle strobe per received byte (may be back-to-back)
//   num_value  last legal token value, held until the next num_valid
//   num_valid  one-cycle pulse: num_value carries a new legal token
//   num_err    one-cycle pulse: token rejected (illegal char or overflow)
//   line_end   one-cycle pulse: end of line (CRLF counts once)
//   tok_cnt    legal tokens since the last line_end, saturating at 15
//
// Every pulse is registered and appears exactly one cycle after the
// rx_done of the byte that decided it.
module uart_num_parser #(
    parameter int unsigned VAL_W   = 8,
    parameter int unsigned MAX_VAL = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_done,
    output logic [VAL_W-1:0] num_value,
    output logic             num_valid,
    output logic             num_err,
    output logic             line_end,
    output logic [3:0]       tok_cnt
);

    // Four spare bits hold (MAX_VAL + 1) * 10 + 9 without wrapping.
    localparam int unsigned AccW = VAL_W + 4;
    localparam int unsigned MulW = AccW + 4;

    localparam logic [MulW-1:0] MaxWide  = MulW'(MAX_VAL);
    localparam logic [AccW-1:0] AccClamp = AccW'(MAX_VAL) + AccW'(1);

    localparam logic [7:0] ChCr = 8'h0D;
    localparam logic [7:0] ChLf = 8'h0A;

    typedef enum logic [1:0] {
        StIdle,
        StNum,
        StSkip
    } state_e;

    state_e            state_q, state_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic              cr_seen_q, cr_seen_d;
    logic [VAL_W-1:0]  num_value_q, num_value_d;
    logic              num_valid_q, num_valid_d;
    logic              num_err_q, num_err_d;
    logic              line_end_q, line_end_d;
    logic [3:0]        tok_cnt_q, tok_cnt_d;

    // Byte classification
    logic            is_digit, is_sep, is_eol, is_cr;
    logic            eol_pulse;
    logic [AccW-1:0] digit_val;
    logic [MulW-1:0] acc_mul;
    logic [3:0]      tok_cnt_base, tok_cnt_inc;

    always_comb begin
        is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
        is_sep    = (rx_data == 8'h20) || (rx_data == 8'h2C);
        is_cr     = (rx_data == ChCr);
        is_eol    = is_cr || (rx_data == ChLf);
        // LF directly after CR belongs to the same line ending.
        eol_pulse = is_eol && !((rx_data == ChLf) && cr_seen_q);
        digit_val = AccW'(rx_data[3:0]);
        acc_mul   = ({4'b0000, acc_q} * MulW'(10)) + MulW'(rx_data[3:0]);
    end

    // A line_end pulse visible this cycle clears the count now; the
    // increment from a token ending in the same cycle was already shown.
    always_comb begin
        tok_cnt_base = line_end_q ? 4'd0 : tok_cnt_q;
        tok_cnt_inc  = (tok_cnt_base == 4'hF) ? 4'hF : tok_cnt_base + 4'd1;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        cr_seen_d   = cr_seen_q;
        num_value_d = num_value_q;
        num_valid_d = 1'b0;
        num_err_d   = 1'b0;
        line_end_d  = 1'b0;
        tok_cnt_d   = tok_cnt_base;

        if (rx_done) begin
            cr_seen_d = is_cr;
            unique case (state_q)
                StIdle: begin
                    if (is_digit) begin
                        state_d = StNum;
                        acc_d   = digit_val;
                        ovf_d   = 1'b0;
                    end else if (is_eol) begin
                        line_end_d = eol_pulse;
                    end else if (!is_sep) begin
                        num_err_d = 1'b1;
                        state_d   = StSkip;
                    end
                end
                StNum: begin
                    if (is_digit) begin
                        if (acc_mul > MaxWide) begin
                            ovf_d = 1'b1;
                            acc_d = AccClamp;
                        end else begin
                            acc_d = acc_mul[AccW-1:0];
                        end
                    end else if (is_sep || is_eol) begin
                        if (ovf_q) begin
                            num_err_d = 1'b1;
                        end else begin
                            num_valid_d = 1'b1;
                            num_value_d = acc_q[VAL_W-1:0];
                            tok_cnt_d   = tok_cnt_inc;
                        end
                        line_end_d = eol_pulse;
                        state_d    = StIdle;
                    end else begin
                        num_err_d = 1'b1;
                        state_d   = StSkip;
                    end
                end
                StSkip: begin
                    if (is_sep || is_eol) begin
                        line_end_d = eol_pulse;
                        state_d    = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cr_seen_q   <= 1'b0;
            num_value_q <= '0;
            num_valid_q <= 1'b0;
            num_err_q   <= 1'b0;
            line_end_q  <= 1'b0;
            tok_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            cr_seen_q   <= cr_seen_d;
            num_value_q <= num_value_d;
            num_valid_q <= num_valid_d;
            num_err_q   <= num_err_d;
            line_end_q  <= line_end_d;
            tok_cnt_q   <= tok_cnt_d;
        end
    end

    assign num_value = num_value_q;
    assign num_valid = num_valid_q;
    assign num_err   = num_err_q;
    assign line_end  = line_end_q;
    assign tok_cnt   = tok_cnt_q;

endmodule

// File: tb/tb_uart_num_parser.sv
// Bench for uart_num_parser: directed strings plus random strings, each byte
// checked one cycle after its rx_done against a token-level model.
module tb_uart_num_parser;

    localparam int MaxVal = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] num_value;
    logic       num_valid, num_err, line_end;
    logic [3:0] tok_cnt;

    int errors = 0;
    int checks = 0;

    uart_num_parser #(
        .VAL_W  (8),
        .MAX_VAL(MaxVal)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .num_value(num_value),
        .num_valid(num_valid),
        .num_err  (num_err),
        .line_end (line_end),
        .tok_cnt  (tok_cnt)
    );

    always #5 clk = ~clk;

    // Token-level model: value kept as an unbounded (capped) integer and
    // judged against MaxVal only when the token ends.
    bit     m_in_tok, m_bad;
    longint m_val;
    byte    m_prev;
    int     m_cnt, m_value;
    bit     e_valid, e_err, e_le;
    int     e_cnt;

    function automatic void model_reset();
        m_in_tok = 0; m_bad = 0; m_val = 0; m_prev = 0; m_cnt = 0; m_value = 0;
    endfunction

    function automatic void model_finish();
        if (m_in_tok) begin
            if (m_val <= MaxVal) begin
                e_valid = 1;
                m_value = int'(m_val);
                if (m_cnt < 15) m_cnt++;
            end else begin
                e_err = 1;
            end
        end
        m_in_tok = 0;
        m_bad = 0;
    endfunction

    function automatic void model_byte(byte b);
        e_valid = 0; e_err = 0; e_le = 0;
        if (b >= 8'h30 && b <= 8'h39) begin
            if (!m_bad) begin
                if (!m_in_tok) begin
                    m_in_tok = 1;
                    m_val = longint'(b - 8'h30);
                end else begin
                    m_val = m_val * 10 + longint'(b - 8'h30);
                    if (m_val > 64'd1000000000) m_val = 64'd1000000000;
                end
            end
        end else if (b == 8'h20 || b == 8'h2C) begin
            model_finish();
        end else if (b == 8'h0D || b == 8'h0A) begin
            model_finish();
            e_le = !(b == 8'h0A && m_prev == 8'h0D);
        end else if (!m_bad) begin
            e_err = 1;
            m_bad = 1;
            m_in_tok = 0;
        end
        m_prev = b;
        e_cnt = m_cnt;
        if (e_le) m_cnt = 0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(bit v, bit er, bit le, int cnt);
        chk("num_valid", 32'(num_valid), 32'(v));
        chk("num_err", 32'(num_err), 32'(er));
        chk("line_end", 32'(line_end), 32'(le));
        chk("num_value", 32'(num_value), 32'(m_value));
        chk("tok_cnt", 32'(tok_cnt), 32'(cnt));
    endtask

    // Entered and left at a negedge; outputs for each byte are checked at
    // the negedge following its rx_done cycle.
    task automatic send_str(string s, int max_gap);
        int gap;
        for (int i = 0; i < s.len(); i++) begin
            rx_data = s[i];
            rx_done = 1'b1;
            @(negedge clk);
            rx_done = 1'b0;
            model_byte(s[i]);
            chk_outputs(e_valid, e_err, e_le, e_cnt);
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) begin
                @(negedge clk);
                chk_outputs(0, 0, 0, m_cnt);
            end
        end
    endtask

    function automatic byte rand_char();
        int r = int'($urandom_range(0, 19));
        byte c;
        if (r < 10) c = 8'h30 + 8'(r);
        else if (r < 12) c = 8'h20;
        else if (r == 12) c = 8'h2C;
        else if (r == 13) c = 8'h0D;
        else if (r < 16) c = 8'h0A;
        else if (r == 16) c = 8'h61;
        else if (r == 17) c = 8'h78;
        else c = 8'h39;
        return c;
    endfunction

    initial begin
        string s;
        rst = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        chk_outputs(0, 0, 0, 0);
        rst = 1'b0;

        send_str("12,34 5\015\012", 0);
        send_str("255 256 0000255\012", 0);
        send_str("99999999 ", 0);
        send_str("1a3 7\012", 0);
        send_str("x\012", 0);
        s = "";
        for (int i = 0; i < 17; i++) s = {s, "1 "};
        send_str(s, 0);
        send_str("\012", 0);
        send_str("  ,,\015\015", 0);
        send_str("\012\012", 0);

        // Reset in the middle of a token discards it.
        send_str("12", 0);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            model_reset();
            chk_outputs(0, 0, 0, 0);
        end
        rst = 1'b0;
        send_str("3 ", 0);

        // Same random string gapless and with random idle gaps.
        for (int k = 0; k < 4; k++) begin
            s = "";
            for (int i = 0; i < 60; i++) s = {s, string'(rand_char())};
            send_str(s, 0);
            send_str(s, 20);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
